// File: rtl/spw_demux_ch_router.sv
// Routes one SpaceWire RX character stream to one of three destinations, or discards it when parked.
// A route change takes effect only between packets, so a packet is never split across destinations.
module spw_demux_ch_router #(
    parameter int DROP_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            sel_i,
    input  logic [8:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [8:0]            out_data,
    output logic [2:0]            out_valid,
    input  logic [2:0]            out_ready,
    output logic [1:0]            active_sel,
    output logic                  sel_pending,
    output logic [DROP_CNT_W-1:0] drop_count,
    input  logic                  drop_clear
);

    typedef enum logic {IDLE = 1'b0, IN_PKT = 1'b1} state_t;

    state_t     state, state_nxt;
    logic       buf_valid;
    logic [8:0] buf_data;
    logic       parked;
    logic       dest_ready;
    logic       accept;
    logic       is_eop;
    logic       drain;
    logic       sel_diff;
    logic       switch_en;

    assign parked   = (active_sel == 2'd3);
    assign accept   = in_valid & in_ready;
    assign is_eop   = in_data[8] & ((in_data[7:0] == 8'h00) | (in_data[7:0] == 8'h01));
    assign drain    = buf_valid & dest_ready;
    assign sel_diff = (sel_i != active_sel);
    assign out_data = buf_data;

    always_comb begin
        dest_ready = 1'b0;
        case (active_sel)
            2'd0:    dest_ready = out_ready[0];
            2'd1:    dest_ready = out_ready[1];
            2'd2:    dest_ready = out_ready[2];
            default: dest_ready = 1'b0;
        endcase
    end

    // A parked route discards chars, so only a packet opening on it blocks the switch.
    always_comb begin
        switch_en = 1'b0;
        if (state == IDLE && sel_diff) begin
            if (parked)
                switch_en = ~(accept & ~is_eop);
            else
                switch_en = ~accept & (~buf_valid | drain);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && !is_eop) state_nxt = IN_PKT;
            IN_PKT:  if (accept && is_eop)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Holding off input while a switch waits on the drain keeps it from being starved.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 3'b000;
        if (reset_n) begin
            if (parked)
                in_ready = 1'b1;
            else if (state == IDLE && buf_valid && sel_pending)
                in_ready = 1'b0;
            else
                in_ready = ~buf_valid | dest_ready;
        end
        if (buf_valid) begin
            case (active_sel)
                2'd0:    out_valid = 3'b001;
                2'd1:    out_valid = 3'b010;
                2'd2:    out_valid = 3'b100;
                default: out_valid = 3'b000;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_valid   <= 1'b0;
            buf_data    <= 9'h000;
            active_sel  <= 2'd3;
            sel_pending <= 1'b0;
        end else begin
            if (accept && !parked) begin
                buf_valid <= 1'b1;
                buf_data  <= in_data;
            end else if (drain) begin
                buf_valid <= 1'b0;
            end
            if (switch_en)
                active_sel <= sel_i;
            sel_pending <= sel_diff & ~switch_en;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            drop_count <= '0;
        else if (drop_clear)
            drop_count <= '0;
        else if (accept && parked && drop_count != {DROP_CNT_W{1'b1}})
            drop_count <= drop_count + 1'b1;
    end

endmodule

// File: tb/tb_spw_demux_ch_router.sv
// Directed bench for spw_demux_ch_router: parking, routing, deferred switching, stalls,
// drop counter saturation/clear and asynchronous reset mid-packet.
module tb_spw_demux_ch_router;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  sel_i;
    logic [8:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  out_data;
    logic [2:0]  out_valid;
    logic [2:0]  out_ready;
    logic [1:0]  active_sel;
    logic        sel_pending;
    logic [15:0] drop_count;
    logic        drop_clear;

    int n_tests = 0;
    int n_fail  = 0;

    spw_demux_ch_router #(.DROP_CNT_W(16)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sel_i       (sel_i),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .active_sel  (active_sel),
        .sel_pending (sel_pending),
        .drop_count  (drop_count),
        .drop_clear  (drop_clear)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n    = 1'b0;
        sel_i      = 2'd3;
        in_data    = 9'h000;
        in_valid   = 1'b0;
        out_ready  = 3'b000;
        drop_clear = 1'b0;
        step();
        step();
        check("rst_in_ready",    in_ready,    0);
        check("rst_out_valid",   out_valid,   0);
        check("rst_out_data",    out_data,    0);
        check("rst_active_sel",  active_sel,  3);
        check("rst_drop_count",  drop_count,  0);
        check("rst_sel_pending", sel_pending, 0);
        reset_n = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        // Parked: six chars discarded
        in_valid = 1'b1;
        in_data = 9'h011; step(); check("park_ov0", out_valid, 0);
        in_data = 9'h022; step(); check("park_ov1", out_valid, 0);
        in_data = 9'h033; step();
        in_data = 9'h044; step();
        in_data = 9'h055; step();
        in_data = 9'h100; step(); check("park_ov5", out_valid, 0);
        in_valid = 1'b0;
        check("park_drop6",  drop_count, 6);
        check("park_active", active_sel, 3);

        // Route 1, full throughput
        sel_i = 2'd1; out_ready = 3'b111;
        step();
        check("sw1_active",  active_sel,  1);
        check("sw1_pending", sel_pending, 0);
        in_valid = 1'b1; in_data = 9'h0A5; step();
        check("r1_ov_a", out_valid, 3'b010); check("r1_od_a", out_data, 9'h0A5);
        in_data = 9'h05A; step();
        check("r1_ov_b", out_valid, 3'b010); check("r1_od_b", out_data, 9'h05A);
        in_data = 9'h100; step();
        check("r1_ov_c", out_valid, 3'b010); check("r1_od_c", out_data, 9'h100);
        in_valid = 1'b0; step();
        check("r1_ov_end", out_valid, 0);

        // Route 0, switch request mid-packet is deferred
        sel_i = 2'd0; step();
        check("sw0_active", active_sel, 0);
        in_valid = 1'b1; in_data = 9'h011; step();
        check("r0_ov_a", out_valid, 3'b001); check("r0_od_a", out_data, 9'h011);
        sel_i = 2'd2; in_data = 9'h022; step();
        check("defer_pending", sel_pending, 1);
        check("defer_active",  active_sel,  0);
        check("defer_ov_b", out_valid, 3'b001); check("defer_od_b", out_data, 9'h022);
        in_data = 9'h100; step();
        check("defer_ov_eop", out_valid, 3'b001); check("defer_od_eop", out_data, 9'h100);
        check("defer_active_eop", active_sel, 0);
        in_valid = 1'b0; step();
        check("sw2_active",  active_sel,  2);
        check("sw2_pending", sel_pending, 0);
        check("sw2_ov_idle", out_valid,   0);
        in_valid = 1'b1; in_data = 9'h033; step();
        check("r2_ov_a", out_valid, 3'b100); check("r2_od_a", out_data, 9'h033);
        in_data = 9'h101; step();
        check("r2_ov_eep", out_valid, 3'b100); check("r2_od_eep", out_data, 9'h101);
        in_valid = 1'b0; step();
        check("r2_ov_end", out_valid, 0);

        // Route 0 with destination stall
        sel_i = 2'd0; step();
        check("sw0b_active", active_sel, 0);
        in_valid = 1'b1; in_data = 9'h0C1; step();
        check("st_od_1", out_data, 9'h0C1);
        in_data = 9'h0C2; step();
        check("st_od_2", out_data, 9'h0C2);
        out_ready = 3'b110; in_data = 9'h0C3; #1;
        check("st_in_ready_a", in_ready, 0);
        step();
        check("st_hold_a_od", out_data, 9'h0C2); check("st_hold_a_ov", out_valid, 3'b001);
        check("st_in_ready_b", in_ready, 0);
        step();
        check("st_hold_b_od", out_data, 9'h0C2); check("st_hold_b_ov", out_valid, 3'b001);
        out_ready = 3'b111; #1;
        check("st_in_ready_c", in_ready, 1);
        step();
        check("st_od_3", out_data, 9'h0C3);
        in_data = 9'h100; step();
        check("st_od_eop", out_data, 9'h100); check("st_ov_eop", out_valid, 3'b001);
        in_valid = 1'b0; step();
        check("st_ov_end", out_valid, 0);

        // Parked: drop counter saturation and clear
        sel_i = 2'd3; step();
        check("sw3_active", active_sel, 3);
        drop_clear = 1'b1; step();
        check("drop_cleared", drop_count, 0);
        drop_clear = 1'b0;
        in_valid = 1'b1; in_data = 9'h0AA;
        for (int i = 0; i < 65535; i++) step();
        check("drop_full", drop_count, 16'hFFFF);
        for (int i = 0; i < 5; i++) step();
        check("drop_sat",    drop_count, 16'hFFFF);
        check("drop_ov",     out_valid,  0);
        drop_clear = 1'b1; step();
        check("drop_clr_accept", drop_count, 0);
        drop_clear = 1'b0;

        // Parked mid-packet: switch waits for the discarded packet's EOP
        in_valid = 1'b0; sel_i = 2'd0; step();
        check("pk_defer_active",  active_sel,  3);
        check("pk_defer_pending", sel_pending, 1);
        in_valid = 1'b1; in_data = 9'h100; step();
        check("pk_eop_active", active_sel, 3);
        check("pk_eop_drop",   drop_count, 1);
        check("pk_eop_ov",     out_valid,  0);
        in_valid = 1'b0; step();
        check("pk_sw_active",  active_sel,  0);
        check("pk_sw_pending", sel_pending, 0);

        // Route 1, reset asserted mid-packet
        sel_i = 2'd1; step();
        check("sw1b_active", active_sel, 1);
        in_valid = 1'b1; in_data = 9'h011; step();
        check("mr_ov", out_valid, 3'b010);
        in_valid = 1'b0; sel_i = 2'd3;
        reset_n = 1'b0; #1;
        check("mr_ov_async",  out_valid,   0);
        check("mr_od_async",  out_data,    0);
        check("mr_active",    active_sel,  3);
        check("mr_in_ready",  in_ready,    0);
        check("mr_drop",      drop_count,  0);
        step();
        reset_n = 1'b1; #1;
        check("mr_rel_in_ready", in_ready, 1);
        sel_i = 2'd2; step();
        check("mr_idle_switch", active_sel, 2);
        sel_i = 2'd3; step();
        check("mr_park", active_sel, 3);
        in_valid = 1'b1; in_data = 9'h044; step();
        in_valid = 1'b0;
        check("mr_discard_ov",   out_valid,  0);
        check("mr_discard_drop", drop_count, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spw_demux_ch_router.md
Name: spw_demux_ch_router

Overview:
- Downstream consumer of the SpaceWire demux channel select register (2-bit select, register reset value 3).
- Routes one SpaceWire receive character stream to one of three destination ports: 0, 1 or 2. Select value 3 parks the channel and discards its traffic.
- Select changes apply only on packet boundaries, so no packet is ever split across destinations.
- Sits between the SpaceWire codec RX FIFO and the per-destination packet consumers.

Parameters:
- DROP_CNT_W, 16, width of the saturating discarded-character counter.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- sel_i  in  2  requested route from the select register; 0..2 = destination, 3 = park/discard
- in_data  in  9  character; bit8=1 marks a control char; control 0x00 = EOP, 0x01 = EEP
- in_valid  in  1  in_data valid
- in_ready  out  1  router accepts in_data this cycle
- out_data  out  9  character shared by all destinations
- out_valid  out  3  one-hot valid, bit n = destination n
- out_ready  in  3  per-destination ready
- active_sel  out  2  route currently in force
- sel_pending  out  1  sel_i differs from active_sel and the switch is deferred
- drop_count  out  DROP_CNT_W  characters discarded while parked, saturating
- drop_clear  in  1  synchronous clear of drop_count

Behaviour:
- Reset values:
  - active_sel = 3; state = IDLE; output buffer empty.
  - out_valid = 0, out_data = 0, drop_count = 0, sel_pending = 0.
  - in_ready = 0 during reset; in_ready = 1 from the first cycle after reset deassertion.
- Input transfer: occurs when in_valid && in_ready.
- Output transfer: occurs when out_valid[n] && out_ready[n].
- Handshake:
  - Single-entry registered output buffer, so latency is 1 cycle from input transfer to out_valid.
  - out_valid is one-hot at bit active_sel, or all-zero.
  - out_data and out_valid are held stable until the transfer completes.
  - Non-parked: in_ready = ~buf_valid | out_ready[active_sel]. This gives full throughput: one char per cycle when the destination is always ready.
  - Parked (active_sel = 3): buffer is empty, in_ready = 1, and every accepted char is discarded.
- End-of-packet char: accepted char with bit8=1 and data[7:0] equal to 0x00 or 0x01. Any other control value is forwarded as ordinary data.
- State machine:
  - IDLE: no packet open. On accepted char: if it is not an end-of-packet char, go to IN_PKT; if it is an end-of-packet char, stay IDLE.
  - IN_PKT: packet open on active_sel. On accepted end-of-packet char, go to IDLE. Other chars keep IN_PKT.
- Switching active_sel:
  - active_sel <= sel_i only when all of: state == IDLE, buffer empty (or draining this cycle with no new accept), and sel_i != active_sel.
  - The update takes effect in that cycle's registered update; chars accepted in the following cycle use the new route.
  - Same cycle as an accepted end-of-packet char: that char still goes to the old route; the switch applies once the buffer has drained.
  - While IDLE with buffer non-empty, in_ready is forced to 0 if sel_pending, so the switch cannot be starved.
  - sel_pending = (sel_i != active_sel) && ~(switch applied this cycle); registered.
  - sel_i changing back to active_sel before the switch clears sel_pending, with no switch.
- Parked, mid-packet: changing sel_i from 3 to n while IN_PKT defers the switch until the discarded packet's end-of-packet char. The destination therefore never sees a packet tail.
- drop_count:
  - Increments on each accepted char while active_sel == 3.
  - Saturates at all-ones.
  - drop_clear has priority over increment and yields 0 on the next cycle.
- Reset asserted mid-packet: all state returns to reset values immediately. The partial packet is not completed; downstream detects it by timeout or EEP policy.
- Destination stall (out_ready[n] = 0): buffer holds, in_ready = 0, no data loss, no switch.

Test Plan:
- After reset, sel_i=3, 5 chars then EOP (6 chars) -> all accepted, out_valid stays 0, drop_count=6, active_sel=3.
- sel_i=1, all out_ready=1, stream packet A5,5A,EOP -> out_valid=3'b010 for 3 consecutive cycles, each starting 1 cycle after its input transfer, with out_data=0x0A5,0x05A,0x100.
- Mid-packet on route 0, set sel_i=2 -> sel_pending=1 and the rest of the packet goes to dest 0. After EOP drains, active_sel=2, sel_pending=0, and the next packet appears on out_valid[2].
- Route 0 with out_ready[0] toggling 1,0,0,1 -> out_data held stable while stalled, in_ready=0 during the stall, and the sequence arrives complete and in order.
- drop_count preset near saturation (drive 65540 chars while parked) -> drop_count=0xFFFF. Then drop_clear together with an accepted char -> drop_count=0 next cycle.
- Assert reset_n=0 mid-packet on route 1 -> out_valid=0 asynchronously, active_sel=3, state IDLE. After release, in_ready=1 and chars are discarded.
